// File: rtl/config_loader_pkg.sv
// Shared definitions for the configuration loader: FSM encodings and the
// CRC-16-CCITT constants plus its single-bit update step.
package config_loader_pkg;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_WORD = 3'd1;
    localparam logic [2:0] ST_SHIFT     = 3'd2;
    localparam logic [2:0] ST_VERIFY    = 3'd3;
    localparam logic [2:0] ST_FINISH    = 3'd4;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

    // MSB-first serial CRC: feedback is the incoming bit xor the register MSB
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/config_loader_crc16_serial.sv
// One-bit-per-cycle CRC-16-CCITT accumulator used by the loader's readback check.
// Only built when CONFIG_LOADER_VERIFY_EN is defined; nothing references it otherwise.
`ifdef CONFIG_LOADER_VERIFY_EN
module crc16_serial
    import config_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= CRC_INIT;
        end else if (clr) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= crc16_step(crc, bit_in);
        end
    end

endmodule
`endif

// File: rtl/config_loader.sv
// Scan-chain configuration loader: serializes words LSB-first onto the chain head.
// Optional readback CRC check of the whole chain when CONFIG_LOADER_VERIFY_EN is defined.
//
// state     | meaning
// IDLE      | waiting for start
// WAIT_WORD | data_ready high, waiting for the next word
// SHIFT     | one buffered bit onto the chain per cycle
// VERIFY    | chain recirculated through scan_return, CRC over returned bits
// FINISH    | one cycle with done set, then back to IDLE
module config_loader
    import config_loader_pkg::*;
#(
    parameter int CHAIN_LENGTH = 32,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic                  scan_out,
    output logic                  scan_en,
    input  logic                  scan_return,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int CW  = $clog2(CHAIN_LENGTH + 1);
    localparam int WCW = $clog2(WORD_WIDTH + 1);
    localparam logic [CW-1:0]  CNT_END  = CW'(CHAIN_LENGTH);
    localparam logic [WCW-1:0] WORD_END = WCW'(WORD_WIDTH);

    logic [2:0]            state;
    logic [WORD_WIDTH-1:0] shift_buf;
    logic [CW-1:0]         bit_cnt;
    logic [WCW-1:0]        word_cnt;
    logic                  done_r;

    logic [CW-1:0]  bit_cnt_nxt;
    logic [WCW-1:0] word_cnt_nxt;
    logic           chain_end;
    logic           word_end;

    assign bit_cnt_nxt  = bit_cnt + CW'(1);
    assign word_cnt_nxt = word_cnt + WCW'(1);
    assign chain_end    = (bit_cnt_nxt == CNT_END);
    // a short final word ends on the chain count, dropping its upper bits
    assign word_end     = (word_cnt_nxt == WORD_END) || chain_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            shift_buf <= '0;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            done_r    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        done_r  <= 1'b0;
                        bit_cnt <= '0;
                        state   <= ST_WAIT_WORD;
                    end
                end
                ST_WAIT_WORD: begin
                    if (data_valid) begin
                        shift_buf <= data_in;
                        word_cnt  <= '0;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    shift_buf <= shift_buf >> 1;
                    bit_cnt   <= bit_cnt_nxt;
                    word_cnt  <= word_cnt_nxt;
                    if (chain_end) begin
`ifdef CONFIG_LOADER_VERIFY_EN
                        bit_cnt <= '0;
                        state   <= ST_VERIFY;
`else
                        done_r  <= 1'b1;
                        state   <= ST_FINISH;
`endif
                    end else if (word_end) begin
                        state <= ST_WAIT_WORD;
                    end
                end
`ifdef CONFIG_LOADER_VERIFY_EN
                ST_VERIFY: begin
                    bit_cnt <= bit_cnt_nxt;
                    if (chain_end) begin
                        done_r <= 1'b1;
                        state  <= ST_FINISH;
                    end
                end
`endif
                ST_FINISH: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    assign data_ready = (state == ST_WAIT_WORD);
    assign busy       = (state != ST_IDLE);
    assign done       = done_r;

`ifdef CONFIG_LOADER_VERIFY_EN
    logic [15:0] crc_load;
    logic [15:0] crc_return;
    logic        crc_clr;
    logic        error_r;

    assign crc_clr = (state == ST_IDLE) && start;

    crc16_serial u_crc_load (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (crc_clr),
        .en     (state == ST_SHIFT),
        .bit_in (shift_buf[0]),
        .crc    (crc_load)
    );

    crc16_serial u_crc_return (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (crc_clr),
        .en     (state == ST_VERIFY),
        .bit_in (scan_return),
        .crc    (crc_return)
    );

    // the last returned bit is folded in here since crc_return lags by a cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            error_r <= 1'b0;
        end else if (crc_clr) begin
            error_r <= 1'b0;
        end else if ((state == ST_VERIFY) && chain_end) begin
            error_r <= (crc_load != crc16_step(crc_return, scan_return));
        end
    end

    assign scan_en  = (state == ST_SHIFT) || (state == ST_VERIFY);
    assign scan_out = (state == ST_SHIFT)  ? shift_buf[0] :
                      (state == ST_VERIFY) ? scan_return  : 1'b0;
    assign error    = error_r;
`else
    logic unused_scan_return;
    assign unused_scan_return = scan_return;

    assign scan_en  = (state == ST_SHIFT);
    assign scan_out = (state == ST_SHIFT) && shift_buf[0];
    assign error    = 1'b0;
`endif

endmodule
